// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and defaults for the four-way round-robin mux arbiter.
// Holds the state encoding and the rotating priority scan.
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int HOLD_CYCLES_DEF = 4;
   localparam int CNT_W_DEF       = 3;

   // First requester at or after ptr, wrapping 3 -> 0.
   function automatic logic [1:0] rr_pick(
      input logic [3:0] req,
      input logic [1:0] ptr
   );
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle of the round-robin mux arbiter.
// master drives requests and data; slave is the arbiter.
interface mux4_rr_arbiter_if #(
   parameter int CNT_W = 3
);
   logic [3:0]       req;
   logic [3:0]       data;
   logic [3:0]       grant;
   logic [1:0]       sel;
   logic             busy;
   logic             m;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output req, data,
      input  grant, sel, busy, m, hold_cnt
   );

   modport slave (
      input  req, data,
      output grant, sel, busy, m, hold_cnt
   );
endinterface

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain 4-to-1 single-bit mux, select {s1,s0}.
// u/v/w/x are inputs 0..3.
module mux4to1 (
   input  logic u,
   input  logic v,
   input  logic w,
   input  logic x,
   input  logic s0,
   input  logic s1,
   output logic y
);
   assign y = s1 ? (s0 ? x : w)
                 : (s0 ? v : u);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters.
// Grants are held at most HOLD_CYCLES cycles with one idle gap between.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   mux4_rr_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       pick;
   logic             busy;
   logic             mux_y;

   assign pick = rr_pick(bus.req, ptr_q);
   assign busy = (state_q == GRANT);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = GRANT;
               grant_d = 4'b0001 << pick;
               sel_d   = pick;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            // sel_q names the owner; it survives release.
            if (!bus.req[sel_q] || cnt_q == LAST) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
               ptr_d   = sel_q + 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   mux4to1 u_mux (
      .u  (bus.data[0]),
      .v  (bus.data[1]),
      .w  (bus.data[2]),
      .x  (bus.data[3]),
      .s0 (sel_q[0]),
      .s1 (sel_q[1]),
      .y  (mux_y)
   );

   assign bus.grant    = grant_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = busy;
   assign bus.hold_cnt = cnt_q;
   assign bus.m        = mux_y & busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table, directed corners and a
// randomized run against a cycle-level reference model.
module tb_mux4_rr_arbiter;

   localparam int HOLD = 4;
   localparam int CW   = 3;

   logic clock;
   logic reset;

   mux4_rr_arbiter_if #(.CNT_W(CW)) bus ();

   mux4_rr_arbiter #(
      .HOLD_CYCLES (HOLD),
      .CNT_W       (CW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int passes = 0;

   // reference model: owner index or -1, cycles already served
   int m_owner  = -1;
   int m_served = 0;
   int m_ptr    = 0;
   int m_sel    = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] data;
      logic [3:0] e_grant;
      logic [1:0] e_sel;
      logic       e_busy;
      logic [2:0] e_hold;
      logic       e_m;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                    name, act, exp, $time);
   endtask

   task automatic model_edge(input logic [3:0] rq, input logic rs);
      bit found;
      int idx;
      if (rs) begin
         m_owner  = -1;
         m_served = 0;
         m_ptr    = 0;
         m_sel    = 0;
      end else if (m_owner < 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!found && rq[idx]) begin
               found    = 1;
               m_owner  = idx;
               m_served = 0;
               m_sel    = idx;
            end
         end
      end else begin
         if (!rq[m_owner] || m_served + 1 == HOLD) begin
            m_ptr    = (m_owner + 1) % 4;
            m_owner  = -1;
            m_served = 0;
         end else begin
            m_served++;
         end
      end
   endtask

   function automatic int exp_m(input logic [3:0] d);
      return (m_owner >= 0) ? int'(d[m_sel]) : 0;
   endfunction

   task automatic check_model(input string tag);
      int eg;
      eg = (m_owner < 0) ? 0 : (1 << m_owner);
      check({tag, ".grant"}, int'(bus.grant), eg);
      check({tag, ".sel"}, int'(bus.sel), m_sel);
      check({tag, ".busy"}, int'(bus.busy), int'(m_owner >= 0));
      check({tag, ".hold"}, int'(bus.hold_cnt), m_served);
      check({tag, ".m"}, int'(bus.m), exp_m(bus.data));
   endtask

   task automatic cycle(input logic [3:0] rq, input logic [3:0] d,
                        input logic rs);
      bus.req  = rq;
      bus.data = d;
      reset    = rs;
      model_edge(rq, rs);
      @(posedge clock);
      #1;
   endtask

   int rises[$];
   logic prev_busy;
   logic [3:0] nd;

   initial begin
      bus.req  = '0;
      bus.data = '0;
      reset    = 1'b1;

      vecs[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 3'd0, 1};
      vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 3'd1, 1};
      vecs[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 3'd2, 1};
      vecs[3]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 3'd3, 1};
      vecs[4]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 0, 3'd0, 0};
      vecs[5]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 3'd0, 1};
      vecs[6]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 3'd0, 0};
      vecs[7]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 3'd0, 1};
      vecs[8]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 3'd1, 0};
      vecs[9]  = '{4'b1000, 4'b1000, 4'b0000, 2'd1, 0, 3'd0, 0};
      vecs[10] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1, 3'd0, 1};
      vecs[11] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1, 3'd1, 0};
      vecs[12] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1, 3'd2, 0};
      vecs[13] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1, 3'd3, 0};
      vecs[14] = '{4'b1001, 4'b0001, 4'b0000, 2'd3, 0, 3'd0, 0};
      vecs[15] = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 3'd0, 1};

      // reset and idle
      cycle(4'b0000, 4'b1111, 1'b1);
      check("rst.grant", int'(bus.grant), 0);
      check("rst.sel", int'(bus.sel), 0);
      check("rst.busy", int'(bus.busy), 0);
      check("rst.m", int'(bus.m), 0);
      for (int i = 0; i < 5; i++) begin
         cycle(4'b0000, 4'b1111, 1'b0);
         check_model("idle");
         check("idle.grant", int'(bus.grant), 0);
      end

      // vector table
      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].req, vecs[i].data, 1'b0);
         check($sformatf("vec%0d.grant", i), int'(bus.grant),
               int'(vecs[i].e_grant));
         check($sformatf("vec%0d.sel", i), int'(bus.sel),
               int'(vecs[i].e_sel));
         check($sformatf("vec%0d.busy", i), int'(bus.busy),
               int'(vecs[i].e_busy));
         check($sformatf("vec%0d.hold", i), int'(bus.hold_cnt),
               int'(vecs[i].e_hold));
         check($sformatf("vec%0d.m", i), int'(bus.m),
               int'(vecs[i].e_m));
      end

      // reset mid-grant after ptr has moved to 3
      cycle(4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < 5; i++) cycle(4'b0100, 4'b0100, 1'b0);
      cycle(4'b0100, 4'b0100, 1'b0);
      cycle(4'b0100, 4'b0100, 1'b0);
      cycle(4'b0100, 4'b0100, 1'b0);
      check("pre_rst.hold", int'(bus.hold_cnt), 2);
      cycle(4'b0100, 4'b0100, 1'b1);
      check("midrst.grant", int'(bus.grant), 0);
      check("midrst.hold", int'(bus.hold_cnt), 0);
      cycle(4'b1010, 4'b0010, 1'b0);
      check("midrst.next", int'(bus.grant), 4'b0010);
      check_model("midrst");

      // fairness with all requesting
      cycle(4'b0000, 4'b0000, 1'b1);
      prev_busy = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cycle(4'b1111, 4'b1010, 1'b0);
         check_model("fair");
         if (bus.busy && !prev_busy) rises.push_back(int'(bus.sel));
         prev_busy = bus.busy;
      end
      check("fair.count", rises.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < rises.size())
            check($sformatf("fair.order%0d", i), rises[i], i % 4);

      // randomized run, with mid-cycle data changes on the mux path
      for (int i = 0; i < 3000; i++) begin
         cycle(4'($urandom), 4'($urandom),
               ($urandom_range(0, 63) == 0));
         check_model("rand");
         nd = 4'($urandom);
         bus.data = nd;
         #1;
         check("rand.mcomb", int'(bus.m), exp_m(nd));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
